alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single 16-bit execute-stage ALU between two requesters: requester 0, the instruction execute path, and requester 1, the auxiliary address/compare path. It runs a valid/ready handshake per requester and round-robin arbitration. Each accepted operation is sequenced through the ALU with registered operands, and the result is returned on a held response channel. Opcodes the ALU does not implement are rejected with an error response and never reach the ALU.

## Interface
- No parameters; the data width is fixed at 16 and the opcode width at 5, matching the ALU.
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i belongs to requester i.
- req_ready  out  2  per-requester accept, combinational; a transfer occurs when valid&ready on the same bit.
- req_op0 / req_op1  in  5 each  ALU opcode.
- req_funct0 / req_funct1  in  2 each  funct field, used only for opcode class 110.
- req_a0 / req_a1, req_b0 / req_b1  in  16 each  operands Ain and Bin.
- rsp_valid  out  2  response valid; at most one bit set.
- rsp_ready  in  2  per-requester response accept.
- rsp_data  out  16  result, shared by both requesters.
- rsp_err  out  1  the responded opcode was illegal; rsp_data is 0.
- alu_op  out  5  opcode to the ALU; 5'b00000 (NOP) outside EXEC.
- alu_funct  out  2  funct to the ALU.
- alu_a, alu_b  out  16  registered operands to the ALU.
- alu_out  in  16  ALU result, combinational from alu_* outputs.
- busy  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **Grant, IDLE only:**
  - If exactly one req_valid is set, that requester is granted.
  - If both are set, the requester named by the priority pointer `prio` is granted.
  - req_ready = one-hot grant while in IDLE, and 0 in every other state.
- **Accept (IDLE with a handshake):**
  - Latch op, funct, a, b and the grant id into operand registers.
  - Legal opcodes are [4:2] in {000, 010, 101, 111}, or [4:2]=110 with [1:0] in {10, 11}.
  - Legal opcode: go to EXEC. Illegal opcode: set err_q, clear the result register, go directly to RESP.
- **EXEC (exactly one cycle):**
  - Drive alu_op/alu_funct/alu_a/alu_b from the operand registers.
  - Capture alu_out into the result register at the cycle end, then go to RESP.
- **RESP:**
  - rsp_valid[gid]=1, rsp_data=result, rsp_err=err_q, all held stable until rsp_ready[gid]=1.
  - rsp_ready on the non-granted bit is ignored.
  - On the handshake: go to IDLE, set prio = ~gid, clear err_q.
- **Fairness:**
  - prio always points away from the last completed requester.
  - Under constant contention, grants strictly alternate.
  - A lone requester is granted back-to-back regardless of prio.
- **Requester obligations:** hold op/funct/a/b stable while valid&&!ready. The arbiter samples them only in the accept cycle.
- **No pipelining:** a new request is never accepted in RESP, including in the cycle of the response handshake.

## Timing
- **Reset values:** state IDLE, prio=0, rsp_valid=0, rsp_data=0, rsp_err=0, alu_op=0, alu_funct=0, alu_a=0, alu_b=0, busy=0. req_ready reflects IDLE grant logic in the first cycle after reset.
- **Latency, legal op:** accept at cycle T, EXEC at T+1, rsp_valid at T+2. Minimum request-to-request spacing is 3 cycles when rsp_ready is already high.
- **Latency, illegal op:** accept at T, rsp_valid at T+1. alu_op stays 0 throughout.
- **Reset in any state:** the transaction is dropped at the next edge; no response is issued, prio returns to 0, and all outputs take their reset values.
- **Request withdrawal:** deasserting req_valid before the handshake is allowed; no state change results.

## Test plan
- **Single legal op:** reset, then requester 0 sends XORI op=01010, a=0x00FF, b=0x0F0F with rsp_ready=1 → req_ready0 in cycle T, alu_op=01010 in T+1, rsp_valid=01 with rsp_data=0x0FF0 and rsp_err=0 in T+2, busy low in T+3.
- **Contention:** both requesters valid immediately after reset, r0 ADD (11011/00, 0x1234+0x0001), r1 ADDI (01000, 0x0002+0x0003) → r0 is served first with rsp_data=0x1235, then r1 with 0x0005. A further double request is granted to r0 again, since prio returns to 0 after the r1 response.
- **Response stall:** hold rsp_ready=0 for 5 cycles during RESP → rsp_valid, rsp_data and rsp_err stay constant, req_ready=00, and busy=1 throughout.
- **Illegal op:** requester 1 sends op=00100 → rsp_valid=10 one cycle after accept, rsp_data=0x0000, rsp_err=1, and alu_op is never nonzero. Also cover op=11000 (class 110 with [1:0]=00), which must produce the same response.
- **Reset mid-EXEC:** assert rst during EXEC → the next cycle is IDLE with all outputs at reset values, and no rsp_valid ever appears for the dropped request.
- **Lone requester:** requester 1 issues 3 requests back-to-back → each is granted, and there is no idle-cycle penalty beyond the 3-cycle spacing.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response handshake bundle between requesters and alu_arbiter
//
// Groups both requesters' request channels and the shared response channel.
//   req_valid/req_ready [1:0]     per-requester request handshake, bit i = requester i
//   req_op0/1 [4:0]               ALU opcode per requester
//   req_funct0/1 [1:0]            funct field per requester (opcode class 110 only)
//   req_a0/1, req_b0/1 [15:0]     operands per requester
//   rsp_valid/rsp_ready [1:0]     per-requester response handshake, at most one valid bit
//   rsp_data [15:0], rsp_err      shared response payload
// Modports: master = requester side, slave = arbiter side.
interface alu_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [4:0]  req_op0;
    logic [4:0]  req_op1;
    logic [1:0]  req_funct0;
    logic [1:0]  req_funct1;
    logic [15:0] req_a0;
    logic [15:0] req_a1;
    logic [15:0] req_b0;
    logic [15:0] req_b1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;

    modport master (
        output req_valid, req_op0, req_op1, req_funct0, req_funct1,
               req_a0, req_a1, req_b0, req_b1, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op0, req_op1, req_funct0, req_funct1,
               req_a0, req_a1, req_b0, req_b1, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one 16-bit ALU between two requesters
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   bus (slave)      request/response handshakes of requesters 0 and 1
//   alu_op/funct     opcode/funct to the ALU, NOP (0) outside EXEC
//   alu_a, alu_b     registered operands to the ALU
//   alu_out          combinational ALU result
//   busy             arbiter is not IDLE
module alu_arbiter (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus,
    output logic [4:0]   alu_op,
    output logic [1:0]   alu_funct,
    output logic [15:0]  alu_a,
    output logic [15:0]  alu_b,
    input  logic [15:0]  alu_out,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state_q, state_d;
    logic        prio_q;
    logic        gid_q;
    logic        err_q;
    logic [4:0]  op_q;
    logic [1:0]  funct_q;
    logic [15:0] a_q, b_q, result_q;

    logic [1:0]  grant;
    logic        sel;
    logic        accept;
    logic        legal;
    logic        rsp_done;
    logic [4:0]  sel_op;
    logic [1:0]  sel_funct;

    // Only a contended cycle consults prio; a lone requester always wins.
    always_comb begin
        grant = 2'b00;
        unique case (bus.req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    assign sel       = grant[1];
    assign sel_op    = sel ? bus.req_op1 : bus.req_op0;
    assign sel_funct = sel ? bus.req_funct1 : bus.req_funct0;
    assign accept    = (state_q == IDLE) && (grant != 2'b00);
    assign rsp_done  = (state_q == RESP) && bus.rsp_ready[gid_q];

    // Class 110 is shared between implemented and unimplemented ops; low bits decide.
    always_comb begin
        legal = 1'b0;
        unique case (sel_op[4:2])
            3'b000, 3'b010, 3'b101, 3'b111: legal = 1'b1;
            3'b110:                         legal = sel_op[1];
            default:                        legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = legal ? EXEC : RESP;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = 2'b00;
        bus.rsp_valid = 2'b00;
        bus.rsp_data  = 16'h0000;
        bus.rsp_err   = 1'b0;
        alu_op        = 5'b00000;
        alu_funct     = 2'b00;
        alu_a         = a_q;
        alu_b         = b_q;
        busy          = (state_q != IDLE);
        unique case (state_q)
            IDLE: bus.req_ready = grant;
            EXEC: begin
                alu_op    = op_q;
                alu_funct = funct_q;
            end
            RESP: begin
                bus.rsp_valid = gid_q ? 2'b10 : 2'b01;
                bus.rsp_data  = result_q;
                bus.rsp_err   = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            gid_q    <= 1'b0;
            err_q    <= 1'b0;
            op_q     <= 5'b00000;
            funct_q  <= 2'b00;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            result_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= sel_op;
                funct_q <= sel_funct;
                a_q     <= sel ? bus.req_a1 : bus.req_a0;
                b_q     <= sel ? bus.req_b1 : bus.req_b0;
                gid_q   <= sel;
                if (!legal) begin
                    err_q    <= 1'b1;
                    result_q <= 16'h0000;
                end
            end
            if (state_q == EXEC) begin
                result_q <= alu_out;
            end
            if (rsp_done) begin
                prio_q <= ~gid_q;
                err_q  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  alu_op;
    logic [1:0]  alu_funct;
    logic [15:0] alu_a, alu_b, alu_out;
    logic        busy;

    alu_arbiter_if bus ();

    alu_arbiter dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_op(alu_op), .alu_funct(alu_funct), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: only the ops exercised here need distinct behaviour.
    function automatic logic [15:0] alu_model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            5'b01010:          return a ^ b;
            5'b01000, 5'b11011: return a + b;
            5'b11010:          return a - b;
            default:           return a | b;
        endcase
    endfunction
    assign alu_out = alu_model(alu_op, alu_a, alu_b);

    typedef struct {
        logic [1:0]  id;
        logic [15:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        int          rid;
        logic [4:0]  op;
        logic [1:0]  funct;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_data;
        logic        exp_err;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[12];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rsp_seen = 0;
    logic saw_alu = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [1:0] id, input logic [15:0] d, input logic err);
        exp_t e;
        e.id = id; e.data = d; e.err = err;
        sb.push_back(e);
    endtask

    task automatic set_req(input int rid, input logic [4:0] op, input logic [1:0] funct,
                           input logic [15:0] a, input logic [15:0] b);
        if (rid == 0) begin
            bus.req_op0 = op; bus.req_funct0 = funct; bus.req_a0 = a; bus.req_b0 = b;
        end else begin
            bus.req_op1 = op; bus.req_funct1 = funct; bus.req_a1 = a; bus.req_b1 = b;
        end
    endtask

    task automatic wait_grant(input logic [1:0] exp_gnt, input string name);
        int n = 0;
        @(negedge clk);
        while (bus.req_ready == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, {30'b0, bus.req_ready}, {30'b0, exp_gnt});
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        @(negedge clk);
        while ((busy || sb.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk(name, {31'b0, busy}, 32'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, {30'b0, bus.rsp_valid}, 32'h0);
        chk({tag, "_rsp_data"},  {16'b0, bus.rsp_data}, 32'h0);
        chk({tag, "_rsp_err"},   {31'b0, bus.rsp_err}, 32'h0);
        chk({tag, "_alu_op"},    {27'b0, alu_op}, 32'h0);
        chk({tag, "_alu_funct"}, {30'b0, alu_funct}, 32'h0);
        chk({tag, "_alu_a"},     {16'b0, alu_a}, 32'h0);
        chk({tag, "_alu_b"},     {16'b0, alu_b}, 32'h0);
        chk({tag, "_busy"},      {31'b0, busy}, 32'h0);
    endtask

    // Response monitor: every handshake pops the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (alu_op != 5'b00000) saw_alu = 1'b1;
            if (bus.rsp_valid != 2'b00) begin
                rsp_seen++;
                chk("rsp_onehot", $countones(bus.rsp_valid), 32'd1);
                if ((bus.rsp_valid & bus.rsp_ready) != 2'b00) begin
                    if (sb.size() == 0) begin
                        chk("rsp_without_request", {30'b0, bus.rsp_valid}, 32'h0);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("rsp_id",   {30'b0, bus.rsp_valid}, {30'b0, mon_e.id});
                        chk("rsp_data", {16'b0, bus.rsp_data},  {16'b0, mon_e.data});
                        chk("rsp_err",  {31'b0, bus.rsp_err},   {31'b0, mon_e.err});
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc[3];
        logic [15:0] la[3];
        logic [15:0] lb[3];
        la[0] = 16'h0100; la[1] = 16'h0200; la[2] = 16'h0300;
        lb[0] = 16'h0001; lb[1] = 16'h0002; lb[2] = 16'h0003;

        vecs[0]  = '{0, 5'b01010, 2'b00, 16'h00FF, 16'h0F0F, 16'h0FF0, 1'b0};
        vecs[1]  = '{1, 5'b01000, 2'b00, 16'h0002, 16'h0003, 16'h0005, 1'b0};
        vecs[2]  = '{0, 5'b11011, 2'b00, 16'h1234, 16'h0001, 16'h1235, 1'b0};
        vecs[3]  = '{1, 5'b11010, 2'b10, 16'h0010, 16'h0001, 16'h000F, 1'b0};
        vecs[4]  = '{0, 5'b10100, 2'b00, 16'hF000, 16'h000F, 16'hF00F, 1'b0};
        vecs[5]  = '{1, 5'b11100, 2'b01, 16'h0A00, 16'h00A0, 16'h0AA0, 1'b0};
        vecs[6]  = '{0, 5'b00000, 2'b00, 16'h0101, 16'h1010, 16'h1111, 1'b0};
        vecs[7]  = '{1, 5'b00100, 2'b00, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1};
        vecs[8]  = '{0, 5'b11000, 2'b00, 16'h1234, 16'h5678, 16'h0000, 1'b1};
        vecs[9]  = '{1, 5'b01100, 2'b00, 16'h1111, 16'h2222, 16'h0000, 1'b1};
        vecs[10] = '{0, 5'b10010, 2'b11, 16'hAAAA, 16'h5555, 16'h0000, 1'b1};
        vecs[11] = '{0, 5'b11001, 2'b00, 16'h0F00, 16'h00F0, 16'h0000, 1'b1};

        rst = 1'b1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        set_req(0, 5'b0, 2'b0, 16'h0, 16'h0);
        set_req(1, 5'b0, 2'b0, 16'h0, 16'h0);
        repeat (3) @(posedge clk);
        #1;

        // Contention straight out of reset, then a repeated double request.
        set_req(0, 5'b11011, 2'b00, 16'h1234, 16'h0001);
        set_req(1, 5'b01000, 2'b00, 16'h0002, 16'h0003);
        bus.rsp_ready = 2'b11;
        bus.req_valid = 2'b11;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset");
        chk("cont_first_grant", {30'b0, bus.req_ready}, 32'h1);
        push(2'b01, 16'h1235, 1'b0);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        wait_grant(2'b10, "cont_second_grant");
        push(2'b10, 16'h0005, 1'b0);
        @(posedge clk); #1;
        bus.req_valid = 2'b11;
        wait_grant(2'b01, "cont_third_grant_r0");
        push(2'b01, 16'h1235, 1'b0);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        wait_grant(2'b10, "cont_alternate_r1");
        push(2'b10, 16'h0005, 1'b0);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        wait_done("cont_done");

        // Single legal op with exact cycle timing.
        set_req(0, 5'b01010, 2'b00, 16'h00FF, 16'h0F0F);
        bus.req_valid = 2'b01;
        @(negedge clk);
        chk("single_ready", {30'b0, bus.req_ready}, 32'h1);
        push(2'b01, 16'h0FF0, 1'b0);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        chk("single_exec_op", {27'b0, alu_op}, 32'h0A);
        chk("single_exec_a", {16'b0, alu_a}, 32'h00FF);
        chk("single_exec_b", {16'b0, alu_b}, 32'h0F0F);
        chk("single_exec_no_rsp", {30'b0, bus.rsp_valid}, 32'h0);
        @(negedge clk);
        chk("single_rsp_valid", {30'b0, bus.rsp_valid}, 32'h1);
        @(negedge clk);
        chk("single_busy_low", {31'b0, busy}, 32'h0);
        @(posedge clk); #1;

        // Illegal op responds one cycle after accept without touching the ALU.
        set_req(1, 5'b00100, 2'b00, 16'h1234, 16'h4321);
        bus.req_valid = 2'b10;
        @(negedge clk);
        chk("illegal_ready", {30'b0, bus.req_ready}, 32'h2);
        push(2'b10, 16'h0000, 1'b1);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        saw_alu = 1'b0;
        @(negedge clk);
        chk("illegal_rsp_valid", {30'b0, bus.rsp_valid}, 32'h2);
        chk("illegal_rsp_err", {31'b0, bus.rsp_err}, 32'h1);
        chk("illegal_rsp_data", {16'b0, bus.rsp_data}, 32'h0);
        wait_done("illegal_done");
        chk("illegal_alu_quiet", {31'b0, saw_alu}, 32'h0);

        // Response stall: held response, no new grant, non-granted ready ignored.
        set_req(0, 5'b01010, 2'b00, 16'h00FF, 16'h0F0F);
        set_req(1, 5'b01000, 2'b00, 16'h0002, 16'h0003);
        bus.rsp_ready = 2'b00;
        bus.req_valid = 2'b01;
        wait_grant(2'b01, "stall_grant");
        push(2'b01, 16'h0FF0, 1'b0);
        @(posedge clk); #1;
        bus.req_valid = 2'b10;
        bus.rsp_ready = 2'b10;
        for (int n = 0; n < 10 && bus.rsp_valid == 2'b00; n++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid", {30'b0, bus.rsp_valid}, 32'h1);
            chk("stall_rsp_data", {16'b0, bus.rsp_data}, 32'h0FF0);
            chk("stall_rsp_err", {31'b0, bus.rsp_err}, 32'h0);
            chk("stall_req_ready", {30'b0, bus.req_ready}, 32'h0);
            chk("stall_busy", {31'b0, busy}, 32'h1);
            @(negedge clk);
        end
        bus.rsp_ready = 2'b11;
        wait_grant(2'b10, "stall_then_r1");
        push(2'b10, 16'h0005, 1'b0);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        wait_done("stall_done");

        // Table of single-requester operations.
        for (int v = 0; v < 12; v++) begin
            set_req(vecs[v].rid, vecs[v].op, vecs[v].funct, vecs[v].a, vecs[v].b);
            bus.req_valid = (vecs[v].rid == 0) ? 2'b01 : 2'b10;
            wait_grant((vecs[v].rid == 0) ? 2'b01 : 2'b10, "vec_grant");
            push((vecs[v].rid == 0) ? 2'b01 : 2'b10, vecs[v].exp_data, vecs[v].exp_err);
            @(posedge clk); #1;
            bus.req_valid = 2'b00;
            saw_alu = 1'b0;
            wait_done("vec_done");
            if (vecs[v].exp_err) chk("vec_illegal_alu_quiet", {31'b0, saw_alu}, 32'h0);
        end

        // Reset during EXEC drops the transaction and restores prio to 0.
        set_req(0, 5'b11011, 2'b00, 16'h1234, 16'h0001);
        bus.req_valid = 2'b01;
        wait_grant(2'b01, "pre_rst_grant");
        push(2'b01, 16'h1235, 1'b0);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        wait_done("pre_rst_done");
        bus.req_valid = 2'b01;
        wait_grant(2'b01, "rst_req_grant");
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        chk("rst_in_exec", {27'b0, alu_op}, 32'h1B);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_seen = 0;
        @(negedge clk);
        chk_reset_outputs("midexec");
        repeat (6) @(negedge clk);
        chk("rst_no_rsp", rsp_seen, 32'h0);
        @(posedge clk); #1;
        bus.req_valid = 2'b11;
        @(negedge clk);
        chk("rst_prio_cleared", {30'b0, bus.req_ready}, 32'h1);
        bus.req_valid = 2'b00;
        @(negedge clk);
        chk("withdraw_no_state_change", {31'b0, busy}, 32'h0);
        @(posedge clk); #1;

        // Lone requester 1 back-to-back with valid held high.
        bus.rsp_ready = 2'b11;
        for (int k = 0; k < 3; k++) begin
            set_req(1, 5'b01000, 2'b00, la[k], lb[k]);
            bus.req_valid = 2'b10;
            wait_grant(2'b10, "lone_grant");
            acc[k] = cyc;
            push(2'b10, la[k] + lb[k], 1'b0);
            @(posedge clk); #1;
        end
        bus.req_valid = 2'b00;
        chk("lone_spacing_1", acc[1] - acc[0], 32'd3);
        chk("lone_spacing_2", acc[2] - acc[1], 32'd3);
        wait_done("lone_done");

        chk("scoreboard_drained", sb.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
